sine_lut_arb: RTL and testbench

SINE_LUT_ARB -- requirements
Module: sine_lut_arb

---
 rtl/sine_lut_arb.sv | 125 ++++++++++++
 tb/tb_sine_lut_arb.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sine_lut_arb.sv
// Round-robin arbiter that lets N_REQ requesters share one combinational sine LUT.
// A granted request drives the LUT address in the same cycle. The LUT result is
// registered into that requester's response slot, so the response arrives one cycle later.
// Optional feature: define SINE_ARB_QWAVE_EN to enable quarter-wave folding.
// With folding enabled, the LUT holds one quadrant and the other three are rebuilt
// by mirroring the index and negating the sample.
module sine_lut_arb #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned ADDR_WD = 10,
  parameter int unsigned GEN_WD  = 16,
`ifdef SINE_ARB_QWAVE_EN
  localparam int unsigned LW     = ADDR_WD - 2
`else
  localparam int unsigned LW     = ADDR_WD
`endif
) (
  input  logic                      clk_f,
  input  logic                      rst_ni,
  input  logic [N_REQ-1:0]          req_valid_i,
  input  logic [N_REQ*ADDR_WD-1:0]  req_addr_i,
  output logic [N_REQ-1:0]          req_ready_o,
  output logic [LW-1:0]             lut_addr_o,
  input  logic [GEN_WD-1:0]         lut_data_i,
  output logic [N_REQ-1:0]          rsp_valid_o,
  output logic [N_REQ*GEN_WD-1:0]   rsp_data_o
);

  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PW-1:0]           ptr_q, ptr_d;
  logic [PW-1:0]           cand;
  logic [PW-1:0]           grant_idx;
  logic                    grant_vld;
  logic [N_REQ-1:0]        grant;
  logic [ADDR_WD-1:0]      sel_addr;
  logic [LW-1:0]           fold_addr;
  logic [LW-1:0]           last_addr_q;
  logic [GEN_WD-1:0]       sample;
  logic [N_REQ-1:0]        rsp_valid_q;
  logic [N_REQ*GEN_WD-1:0] rsp_data_q;

  // Round-robin search from ptr upwards with wrap; the first valid index wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = PW'((32'(ptr_q) + i) % N_REQ);
      if (!grant_vld && req_valid_i[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
    // No grant can be issued while reset is held.
    if (!rst_ni) begin
      grant_vld = 1'b0;
    end
  end

  // Expand the granted index to a one-hot ready vector.
  always_comb begin
    grant = '0;
    if (grant_vld) begin
      grant[grant_idx] = 1'b1;
    end
  end

  // Pointer moves one past the winner; it holds when there is no handshake.
  always_comb begin
    ptr_d = ptr_q;
    if (grant_vld) begin
      ptr_d = (32'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + PW'(1);
    end
  end

`ifdef SINE_ARB_QWAVE_EN
  logic [1:0]    quad;
  logic [LW-1:0] quad_idx;

  // Fold the phase into one quadrant; odd quadrants run the index backwards and
  // the lower half-wave is negated on the way into the response register.
  always_comb begin
    sel_addr  = req_addr_i[grant_idx*ADDR_WD +: ADDR_WD];
    quad      = sel_addr[ADDR_WD-1 -: 2];
    quad_idx  = sel_addr[LW-1:0];
    fold_addr = quad[0] ? ~quad_idx : quad_idx;
    sample    = quad[1] ? ({GEN_WD{1'b0}} - lut_data_i) : lut_data_i;
  end
`else
  // Pass the granted phase straight to the LUT and keep the data unchanged.
  always_comb begin
    sel_addr  = req_addr_i[grant_idx*ADDR_WD +: ADDR_WD];
    fold_addr = sel_addr;
    sample    = lut_data_i;
  end
`endif

  // Drive the LUT from the winner. With no winner, repeat the last address so
  // the LUT input does not toggle.
  always_comb begin
    lut_addr_o = grant_vld ? fold_addr : last_addr_q;
  end

  // State update: pointer, held LUT address, response strobe and sample slots.
  always_ff @(posedge clk_f or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q       <= '0;
      last_addr_q <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= grant;
      if (grant_vld) begin
        last_addr_q                               <= fold_addr;
        rsp_data_q[grant_idx*GEN_WD +: GEN_WD]    <= sample;
      end
    end
  end

  assign req_ready_o = grant;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;

endmodule

// File: tb/tb_sine_lut_arb.sv
// Self-checking bench for sine_lut_arb.
// A reference model written from the arbitration and folding rules predicts every cycle.
// It predicts grants, the LUT address and the registered responses.
// The bench follows the DUT's SINE_ARB_QWAVE_EN setting.
module tb_sine_lut_arb;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 10;
  localparam int unsigned GW = 16;
`ifdef SINE_ARB_QWAVE_EN
  localparam int unsigned LW = AW - 2;
`else
  localparam int unsigned LW = AW;
`endif

  logic              clk_f = 1'b0;
  logic              rst_ni = 1'b0;
  logic [N-1:0]      req_valid_i = '0;
  logic [N*AW-1:0]   req_addr_i = '0;
  logic [N-1:0]      req_ready_o;
  logic [LW-1:0]     lut_addr_o;
  logic [GW-1:0]     lut_data_i;
  logic [N-1:0]      rsp_valid_o;
  logic [N*GW-1:0]   rsp_data_o;

  // LUT stand-in: a scrambled function of the address, or a forced value.
  logic              lut_ovr = 1'b0;
  logic [GW-1:0]     lut_ovr_val = '0;

  int tests = 0;
  int fails = 0;

  // Reference model state.
  int                m_ptr;
  logic [LW-1:0]     m_last;
  logic [N-1:0]      m_rv;
  logic [N*GW-1:0]   m_data;
  // Prediction for the cycle in progress.
  int                p_k;
  logic [LW-1:0]     p_addr;
  logic [GW-1:0]     p_sample;

  sine_lut_arb #(
    .N_REQ   (N),
    .ADDR_WD (AW),
    .GEN_WD  (GW)
  ) dut (
    .clk_f       (clk_f),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_addr_i  (req_addr_i),
    .req_ready_o (req_ready_o),
    .lut_addr_o  (lut_addr_o),
    .lut_data_i  (lut_data_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_data_o  (rsp_data_o)
  );

  always #5 clk_f = ~clk_f;

  function automatic logic [GW-1:0] lut_fn(input logic [LW-1:0] a);
    logic [31:0] h;
    h = 32'(a) * 32'h9E37 + 32'h1357;
    return h[GW-1:0] ^ h[31:16];
  endfunction

  assign lut_data_i = lut_ovr ? lut_ovr_val : lut_fn(lut_addr_o);

  task automatic model_reset();
    m_ptr  = 0;
    m_last = '0;
    m_rv   = '0;
    m_data = '0;
  endtask

  task automatic rand_addrs();
    for (int k = 0; k < N; k++) req_addr_i[k*AW +: AW] = AW'($urandom);
  endtask

  // Work out the cycle's expected grant and sample from the current inputs.
  task automatic predict();
    int unsigned a, q, idx, d;
    p_k = -1;
    p_addr = m_last;
    p_sample = '0;
    if (rst_ni) begin
      for (int i = 0; i < N; i++) begin
        if (p_k < 0 && req_valid_i[(m_ptr + i) % N]) p_k = (m_ptr + i) % N;
      end
    end
    if (p_k >= 0) begin
      a = 32'(req_addr_i[p_k*AW +: AW]);
`ifdef SINE_ARB_QWAVE_EN
      q = a >> LW;
      idx = a % (1 << LW);
      p_addr = LW'((q == 1 || q == 3) ? ((1 << LW) - 1 - idx) : idx);
`else
      q = 0;
      idx = a;
      p_addr = LW'(idx);
`endif
      d = 32'(lut_ovr ? lut_ovr_val : lut_fn(p_addr));
      p_sample = GW'((q >= 2) ? ((1 << GW) - d) : d);
    end
  endtask

  function automatic logic [N-1:0] exp_ready();
    return (p_k >= 0) ? N'(1 << p_k) : '0;
  endfunction

  // Clock edge: commit the prediction to the model, then step off the edge.
  task automatic advance();
    @(posedge clk_f);
    if (rst_ni) begin
      m_rv = exp_ready();
      if (p_k >= 0) begin
        m_data[p_k*GW +: GW] = p_sample;
        m_ptr  = (p_k + 1) % N;
        m_last = p_addr;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    req_valid_i = '1;
    rand_addrs();
    model_reset();
    repeat (3) @(posedge clk_f);
    @(negedge clk_f);
    tests++;
    if (req_ready_o !== '0) begin
      fails++; $display("FAIL reset_ready: got %b expected 0", req_ready_o);
    end
    tests++;
    if (rsp_valid_o !== '0) begin
      fails++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid_o);
    end
    tests++;
    if (rsp_data_o !== '0) begin
      fails++; $display("FAIL reset_rsp_data: got %h expected 0", rsp_data_o);
    end
    tests++;
    if (lut_addr_o !== '0) begin
      fails++; $display("FAIL reset_lut_addr: got %h expected 0", lut_addr_o);
    end
    @(posedge clk_f);
    #1;
    rst_ni = 1'b1;
  endtask

  // All requesters valid right after reset: grants rotate 0,1,2,3,0,1,2,3.
  task automatic test_round_robin();
    logic [N-1:0] want;
    for (int c = 0; c < 9; c++) begin
      req_valid_i = (c < 8) ? '1 : '0;
      rand_addrs();
      @(negedge clk_f);
      predict();
      want = (c < 8) ? N'(1 << (c % 4)) : '0;
      tests++;
      if (req_ready_o !== want) begin
        fails++; $display("FAIL rr_grant c=%0d: got %b expected %b", c, req_ready_o, want);
      end
      want = (c > 0) ? N'(1 << ((c - 1) % 4)) : '0;
      tests++;
      if (rsp_valid_o !== want) begin
        fails++; $display("FAIL rr_rsp_valid c=%0d: got %b expected %b", c, rsp_valid_o, want);
      end
      tests++;
      if (lut_addr_o !== p_addr) begin
        fails++; $display("FAIL rr_lut_addr c=%0d: got %h expected %h", c, lut_addr_o, p_addr);
      end
      tests++;
      if (rsp_data_o !== m_data) begin
        fails++; $display("FAIL rr_rsp_data c=%0d: got %h expected %h", c, rsp_data_o, m_data);
      end
      advance();
    end
  endtask

  // Lone requester 2 at phase 5 is granted every cycle; only its slot changes.
  task automatic test_single();
    lut_ovr = 1'b1;
    lut_ovr_val = 16'h1234;
    rand_addrs();
    req_addr_i[2*AW +: AW] = 10'd5;
    req_valid_i = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_f);
      predict();
      tests++;
      if (req_ready_o !== 4'b0100) begin
        fails++; $display("FAIL single_ready c=%0d: got %b expected 0100", c, req_ready_o);
      end
      tests++;
      if (lut_addr_o !== LW'(5)) begin
        fails++; $display("FAIL single_lut_addr c=%0d: got %h expected 5", c, lut_addr_o);
      end
      if (c > 0) begin
        tests++;
        if (rsp_valid_o !== 4'b0100) begin
          fails++; $display("FAIL single_rsp_valid c=%0d: got %b expected 0100", c, rsp_valid_o);
        end
        tests++;
        if (rsp_data_o[2*GW +: GW] !== 16'h1234) begin
          fails++;
          $display("FAIL single_slot2 c=%0d: got %h expected 1234", c, rsp_data_o[2*GW +: GW]);
        end
        tests++;
        if (rsp_data_o !== m_data) begin
          fails++; $display("FAIL single_slots c=%0d: got %h expected %h", c, rsp_data_o, m_data);
        end
      end
      advance();
    end
    lut_ovr = 1'b0;
  endtask

  // Requesters 1 and 3 with ptr=2 alternate 3,1,3.
  task automatic test_pair();
    logic [N-1:0] want [3];
    want[0] = 4'b1000;
    want[1] = 4'b0010;
    want[2] = 4'b1000;
    req_valid_i = 4'b0010;
    rand_addrs();
    @(negedge clk_f);
    predict();
    advance();
    req_valid_i = 4'b1010;
    for (int c = 0; c < 3; c++) begin
      rand_addrs();
      @(negedge clk_f);
      predict();
      tests++;
      if (req_ready_o !== want[c]) begin
        fails++; $display("FAIL pair_grant c=%0d: got %b expected %b", c, req_ready_o, want[c]);
      end
      tests++;
      if (rsp_data_o !== m_data) begin
        fails++; $display("FAIL pair_slots c=%0d: got %h expected %h", c, rsp_data_o, m_data);
      end
      advance();
    end
    req_valid_i = '0;
  endtask

  // Reset right after a handshake swallows the response.
  task automatic test_reset_mid();
    req_valid_i = 4'b0001;
    rand_addrs();
    @(negedge clk_f);
    predict();
    tests++;
    if (req_ready_o !== 4'b0001) begin
      fails++; $display("FAIL rmid_grant: got %b expected 0001", req_ready_o);
    end
    @(posedge clk_f);
    #1;
    rst_ni = 1'b0;
    model_reset();
    @(negedge clk_f);
    tests++;
    if (rsp_valid_o !== '0) begin
      fails++; $display("FAIL rmid_rsp_valid_in_reset: got %b expected 0", rsp_valid_o);
    end
    tests++;
    if (req_ready_o !== '0) begin
      fails++; $display("FAIL rmid_ready_in_reset: got %b expected 0", req_ready_o);
    end
    @(posedge clk_f);
    #1;
    rst_ni = 1'b1;
    req_valid_i = '0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk_f);
      predict();
      tests++;
      if (rsp_valid_o !== '0) begin
        fails++; $display("FAIL rmid_rsp_valid c=%0d: got %b expected 0", c, rsp_valid_o);
      end
      tests++;
      if (rsp_data_o[0 +: GW] !== '0) begin
        fails++; $display("FAIL rmid_slot0 c=%0d: got %h expected 0", c, rsp_data_o[0 +: GW]);
      end
      advance();
    end
  endtask

`ifdef SINE_ARB_QWAVE_EN
  // Phase 0x305 sits in quadrant 3: mirrored index and negated sample.
  task automatic test_qwave();
    lut_ovr = 1'b1;
    lut_ovr_val = 16'h0100;
    req_valid_i = 4'b0001;
    req_addr_i[0 +: AW] = 10'h305;
    @(negedge clk_f);
    predict();
    tests++;
    if (lut_addr_o !== 8'hFA) begin
      fails++; $display("FAIL qwave_lut_addr: got %h expected fa", lut_addr_o);
    end
    advance();
    req_valid_i = '0;
    @(negedge clk_f);
    predict();
    tests++;
    if (rsp_valid_o !== 4'b0001) begin
      fails++; $display("FAIL qwave_rsp_valid: got %b expected 0001", rsp_valid_o);
    end
    tests++;
    if (rsp_data_o[0 +: GW] !== 16'hFF00) begin
      fails++; $display("FAIL qwave_slot0: got %h expected ff00", rsp_data_o[0 +: GW]);
    end
    advance();
    lut_ovr = 1'b0;
  endtask
`endif

  // Random traffic, including requests dropped without a handshake.
  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      req_valid_i = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 1) << $urandom_range(0, N - 1))
                                                : N'($urandom);
      rand_addrs();
      @(negedge clk_f);
      predict();
      tests++;
      if (req_ready_o !== exp_ready()) begin
        fails++; $display("FAIL rand_ready c=%0d: got %b expected %b", c, req_ready_o, exp_ready());
      end
      tests++;
      if (lut_addr_o !== p_addr) begin
        fails++; $display("FAIL rand_lut_addr c=%0d: got %h expected %h", c, lut_addr_o, p_addr);
      end
      tests++;
      if (rsp_valid_o !== m_rv) begin
        fails++; $display("FAIL rand_rsp_valid c=%0d: got %b expected %b", c, rsp_valid_o, m_rv);
      end
      tests++;
      if (rsp_data_o !== m_data) begin
        fails++; $display("FAIL rand_rsp_data c=%0d: got %h expected %h", c, rsp_data_o, m_data);
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_pair();
    test_reset_mid();
`ifdef SINE_ARB_QWAVE_EN
    test_qwave();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
